sobel_stream_filter: RTL and testbench

// - Streaming successor of the memory-addressed Sobel executor. Consumes one raster-order

---
 rtl/sobel_stream_filter.sv | 232 +++++++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter
//   Streaming 3x3 Sobel edge filter. Takes one raster-order grayscale frame
//   over a valid/ready input stream and produces one result per complete
//   window, in raster order, at up to one pixel per cycle.
//   Two line buffers hold the previous two rows. Two column registers plus
//   the incoming column form the 3x3 window.
//
//   Build option SOBEL_MAG_OUT_EN:
//     defined   -> out_pixel_o is the Sobel magnitude, saturated to the pixel
//                  range. threshold_i is ignored.
//     undefined -> out_pixel_o is all-ones when mag < threshold and 0
//                  otherwise, so edges come out dark.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      frame start, rising edge triggers (ignored unless idle)
//   threshold_i  edge threshold, captured on the start edge
//   in_valid_i   input pixel valid
//   in_ready_o   input pixel accepted when valid & ready
//   in_pixel_i   input pixel
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  downstream ready
//   out_pixel_o  result pixel
//   out_last_o   flags the final result of the frame
//   busy_o       high while a frame is in progress
//   done_o       one-cycle pulse after the final result handshake
//
// state | meaning
// IDLE  | waiting for a start edge
// RUN   | accepting input pixels
// DRAIN | all pixels accepted, flushing the pipeline to the last result
module sobel_stream_filter #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 64,
   parameter int IMG_H      = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH+2:0] threshold_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_pixel_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_pixel_o,
   output logic                  out_last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = DATA_WIDTH + 3;
   localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state;
   logic                    start_q;
   logic [GW-1:0]           thr_q;
   logic [CW-1:0]           col;
   logic [RW-1:0]           row;
   logic                    busy_q;
   logic                    done_q;

   logic [DATA_WIDTH-1:0]   lb_top [IMG_W];
   logic [DATA_WIDTH-1:0]   lb_mid [IMG_W];
   logic [DATA_WIDTH-1:0]   w0 [3];
   logic [DATA_WIDTH-1:0]   w1 [3];
   logic [DATA_WIDTH-1:0]   win [3][3];

   logic                    start_edge;
   logic                    pipe_en;
   logic                    accept;
   logic                    last_px;
   logic                    win_done;

   logic signed [GW-1:0]    gx_c;
   logic signed [GW-1:0]    gy_c;
   logic signed [GW-1:0]    s1_gx;
   logic signed [GW-1:0]    s1_gy;
   logic                    s1_valid;
   logic                    s1_last;
   logic [GW-1:0]           abs_gx;
   logic [GW-1:0]           abs_gy;
   logic [GW-1:0]           mag;
   logic [DATA_WIDTH-1:0]   pix_c;

   logic                    out_valid_q;
   logic                    out_last_q;
   logic [DATA_WIDTH-1:0]   out_pixel_q;

   function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
      return $signed({3'b000, p});
   endfunction

   assign start_edge = start_i & ~start_q;
   // Output register free: either empty or being drained this cycle.
   // This also keeps the pipeline moving during DRAIN, when no input is accepted.
   assign pipe_en    = ~out_valid_q | out_ready_i;
   assign in_ready_o = (state == RUN) & pipe_en;
   assign accept     = in_valid_i & in_ready_o;
   assign last_px    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign win_done   = (row >= RW'(2)) && (col >= CW'(2));

   // Window rows are oldest..newest. Column 2 is the column arriving this cycle.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win[i][0] = w0[i];
         win[i][1] = w1[i];
      end
      win[0][2] = lb_top[col];
      win[1][2] = lb_mid[col];
      win[2][2] = in_pixel_i;
   end

   always_comb begin
      gx_c = ext(win[0][2]) - ext(win[0][0])
           + ((ext(win[1][2]) - ext(win[1][0])) <<< 1)
           + ext(win[2][2]) - ext(win[2][0]);
      gy_c = ext(win[2][0]) - ext(win[0][0])
           + ((ext(win[2][1]) - ext(win[0][1])) <<< 1)
           + ext(win[2][2]) - ext(win[0][2]);
   end

   // |g| is at most 4*(2^DATA_WIDTH-1), so the sum still fits in GW bits.
   always_comb begin
      abs_gx = s1_gx[GW-1] ? GW'(-s1_gx) : GW'(s1_gx);
      abs_gy = s1_gy[GW-1] ? GW'(-s1_gy) : GW'(s1_gy);
      mag    = abs_gx + abs_gy;
`ifdef SOBEL_MAG_OUT_EN
      pix_c  = (mag > {3'b000, PIX_MAX}) ? PIX_MAX : mag[DATA_WIDTH-1:0];
`else
      pix_c  = (mag < thr_q) ? PIX_MAX : '0;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         start_q <= 1'b0;
         thr_q   <= '0;
         col     <= '0;
         row     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         start_q <= start_i;
         done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  thr_q  <= threshold_i;
                  col    <= '0;
                  row    <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (col == CW'(IMG_W - 1)) begin
                     col <= '0;
                     row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
                  if (last_px) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_valid_q && out_ready_i && out_last_q) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb_top[i] <= '0;
            lb_mid[i] <= '0;
         end
         for (int i = 0; i < 3; i++) begin
            w0[i] <= '0;
            w1[i] <= '0;
         end
         s1_gx       <= '0;
         s1_gy       <= '0;
         s1_valid    <= 1'b0;
         s1_last     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         if (accept) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= in_pixel_i;
            for (int i = 0; i < 3; i++) begin
               w0[i] <= w1[i];
               w1[i] <= win[i][2];
            end
         end
         if (pipe_en) begin
            s1_valid    <= accept & win_done;
            s1_last     <= accept & last_px;
            s1_gx       <= gx_c;
            s1_gy       <= gy_c;
            out_valid_q <= s1_valid;
            out_last_q  <= s1_valid & s1_last;
            out_pixel_q <= s1_valid ? pix_c : '0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_pixel_o = out_pixel_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter. Expected results come from a
// direct 3x3 kernel convolution over a stored frame.
module tb_sobel_stream_filter;

   localparam int DW   = 8;
   localparam int W    = 64;
   localparam int H    = 64;
   localparam int N    = (W - 2) * (H - 2);
   localparam int MAXV = 255;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [DW+2:0] threshold_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_pixel_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_pixel_o;
   logic          out_last_o;
   logic          busy_o;
   logic          done_o;

   int n_checks = 0;
   int n_errors = 0;
   int img [W*H];
   int exp_q [$];
   int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   sobel_stream_filter #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .threshold_i (threshold_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_pixel_i  (in_pixel_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_pixel_o (out_pixel_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int ref_pix(input int r, input int c, input int thr);
      int gx = 0;
      int gy = 0;
      int mag;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            gx += kx[i][j] * img[(r + i) * W + c + j];
            gy += ky[i][j] * img[(r + i) * W + c + j];
         end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
      return (mag > MAXV) ? MAXV : mag;
`else
      return (mag < thr) ? MAXV : 0;
`endif
   endfunction

   task automatic build_expected(input int thr);
      exp_q.delete();
      for (int r = 0; r <= H - 3; r++)
         for (int c = 0; c <= W - 3; c++)
            exp_q.push_back(ref_pix(r, c, thr));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid_o, 0);
      chk({tag, "_out_pixel"}, out_pixel_o, 0);
      chk({tag, "_out_last"},  out_last_o, 0);
      chk({tag, "_busy"},      busy_o, 0);
      chk({tag, "_done"},      done_o, 0);
      chk({tag, "_in_ready"},  in_ready_o, 0);
   endtask

   // Runs one frame from the current img[]. Called and returning at posedge+#1.
   task automatic run_frame(input int thr, input bit rand_valid, input bit bp,
                            input bit spurious, input bit chk_lat, input int abort_after);
      int idx = 0;
      int k = 0;
      int cyc = 0;
      int acc_cyc = -1;
      int last_hs_cyc = -1;
      int done_cnt = 0;
      bit held = 0;
      int held_pix = 0;
      int held_last = 0;
      build_expected(thr);
      threshold_i = thr[DW+2:0];
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      threshold_i = DW'($urandom);
      while (cyc < 20000 && done_cnt == 0) begin
         in_valid_i  = (idx < W * H) && (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
         in_pixel_i  = (idx < W * H) ? DW'(img[idx]) : '0;
         out_ready_i = bp ? (((cyc / 3) % 2) == 0) : 1'b1;
         start_i     = spurious && (k < N / 2) && ((cyc % 97) == 5);
         @(negedge clk_i);
         if (held) begin
            chk("stall_valid", out_valid_o, 1);
            chk("stall_pixel", out_pixel_o, held_pix);
            chk("stall_last",  out_last_o, held_last);
         end
         held      = out_valid_o && !out_ready_i;
         held_pix  = out_pixel_o;
         held_last = out_last_o;
         chk("busy", busy_o, done_o ? 0 : 1);
         if (idx == W * H) chk("ready_in_drain", in_ready_o, 0);
         if (out_valid_o && out_ready_i) begin
            if (k < N) begin
               chk("out_pixel", out_pixel_o, exp_q[k]);
               chk("out_last", out_last_o, (k == N - 1) ? 1 : 0);
            end else begin
               chk("output_count", k + 1, N);
            end
            if (chk_lat && k == 0) chk("latency", cyc - acc_cyc, 2);
            k++;
            if (k == N) last_hs_cyc = cyc;
         end
         if (done_o) begin
            done_cnt++;
            chk("done_timing", cyc, last_hs_cyc + 1);
         end
         if (in_valid_i && in_ready_o) begin
            if (idx == 2 * W + 2) acc_cyc = cyc;
            idx++;
         end
         @(posedge clk_i); #1;
         cyc++;
         if (abort_after > 0 && idx == abort_after) begin
            rst_i = 1'b1;
            in_valid_i = 1'b0;
            start_i = 1'b0;
            @(posedge clk_i); #1;
            check_idle_outputs("abort");
            rst_i = 1'b0;
            for (int i = 0; i < 6; i++) begin
               @(posedge clk_i); #1;
               chk("abort_no_done", done_o, 0);
               chk("abort_idle", busy_o, 0);
            end
            return;
         end
      end
      in_valid_i = 1'b0;
      start_i = 1'b0;
      chk("frame_outputs", k, N);
      chk("done_count", done_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("post_done_low", done_o, 0);
         chk("post_idle", busy_o, 0);
         chk("post_no_valid", out_valid_o, 0);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < W * H; i++) img[i] = $urandom_range(0, MAXV);
   endtask

   initial begin
      rst_i = 1'b1;
      start_i = 1'b1;
      threshold_i = '0;
      in_valid_i = 1'b0;
      in_pixel_i = '0;
      out_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_idle_outputs("reset");
      start_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      chk("idle_not_ready", in_ready_o, 0);
      chk("reset_beats_start", busy_o, 0);
      in_valid_i = 1'b0;

      for (int i = 0; i < W * H; i++) img[i] = 100;
      run_frame(50, 1'b0, 1'b0, 1'b0, 1'b1, 0);

      for (int i = 0; i < W * H; i++) img[i] = ((i % W) < 32) ? 0 : 200;
      run_frame(50, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      for (int i = 0; i < W * H; i++) img[i] = 0;
      img[5 * W + 5] = 10;
      run_frame(15, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      fill_random();
      run_frame($urandom_range(0, 1200), 1'b1, 1'b1, 1'b0, 1'b0, 0);

      fill_random();
      run_frame($urandom_range(0, 1200), 1'b1, 1'b0, 1'b0, 1'b0, 1000);

      fill_random();
      run_frame($urandom_range(0, 1200), 1'b1, 1'b0, 1'b0, 1'b0, 0);

      fill_random();
      run_frame($urandom_range(0, 1200), 1'b1, 1'b0, 1'b1, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
